irq_priority_encoder: RTL and testbench

Sequential N-to-W priority encoder. It is the inverse direction of the CPU's binary-to-one-hot decoders.
- Latches multi-hot request lines (interrupt/exception sources) into a pending register.
- Selects one eligible request and presents its binary index to the CPU control path through a valid/ack handshake.
- Sits between the peripheral/exception request lines and the CPU control unit.

---
 rtl/irq_priority_encoder.sv | 130 +++++++++++++
 tb/tb_irq_priority_encoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_priority_encoder.sv
// Sequential N-to-W priority encoder: latches multi-hot requests, grants one via valid/ack.
// Optional build macro ROUND_ROBIN_EN replaces fixed lowest-index priority with a rotating pointer.
module irq_priority_encoder #(
    parameter int W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [(1<<W)-1:0]    req,
    input  logic [(1<<W)-1:0]    mask,
    input  logic                 ack,
    output logic                 valid,
    output logic [W-1:0]         code,
    output logic [(1<<W)-1:0]    onehot,
    output logic [(1<<W)-1:0]    pending
);

    localparam int N = 1 << W;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_code;
    logic [W-1:0]   w_code_nxt;
    logic [N-1:0]   r_onehot;
    logic [N-1:0]   w_onehot_nxt;
    logic [N-1:0]   r_pending;
    logic [N-1:0]   w_pending_nxt;
    logic [N-1:0]   w_eligible;
    logic [N-1:0]   w_clr;
    logic [W-1:0]   w_win;
    logic           w_any;
    logic           w_accept;

    assign w_eligible = r_pending & mask;
    assign w_accept   = (r_state == S_PRESENT) && ack;
    // A request arriving in the same cycle as its own clear keeps the bit pending.
    assign w_clr         = w_accept ? r_onehot : '0;
    assign w_pending_nxt = (r_pending & ~w_clr) | req;

`ifdef ROUND_ROBIN_EN
    logic [W-1:0]   r_ptr;
    logic [W-1:0]   w_ptr_nxt;
    logic [W-1:0]   w_idx;

    // Descending scan so the last hit is the first eligible index at or after r_ptr.
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        w_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = r_ptr + W'(k);
            if (w_eligible[w_idx]) begin
                w_win = w_idx;
                w_any = 1'b1;
            end
        end
    end

    assign w_ptr_nxt = w_accept ? (r_code + W'(1)) : r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end
`else
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_win = W'(i);
                w_any = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_code_nxt   = r_code;
        w_onehot_nxt = r_onehot;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt  = S_PRESENT;
                    w_code_nxt   = w_win;
                    w_onehot_nxt = N'(1) << w_win;
                end
            end
            S_PRESENT: begin
                // Grant is frozen until accepted; mask/req changes are ignored here.
                if (ack) begin
                    w_state_nxt  = S_IDLE;
                    w_onehot_nxt = '0;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_onehot_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_code    <= '0;
            r_onehot  <= '0;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_code    <= w_code_nxt;
            r_onehot  <= w_onehot_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    assign valid   = (r_state == S_PRESENT);
    assign code    = r_code;
    assign onehot  = r_onehot;
    assign pending = r_pending;

endmodule

// File: tb/tb_irq_priority_encoder.sv
// Bench for irq_priority_encoder (W=2): directed plan plus randomized traffic against a behavioural model.
module tb_irq_priority_encoder;

    localparam int W = 2;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] mask;
    logic         ack;
    logic         valid;
    logic [W-1:0] code;
    logic [N-1:0] onehot;
    logic [N-1:0] pending;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    irq_priority_encoder #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .mask    (mask),
        .ack     (ack),
        .valid   (valid),
        .code    (code),
        .onehot  (onehot),
        .pending (pending)
    );

    always #5 clk = ~clk;

    // Reference model: pending as a set of bits, grant as (valid, index), pointer as an integer.
    bit           m_valid;
    int           m_code;
    int           m_ptr;
    logic [N-1:0] m_pend;

    always @(posedge clk) begin : model
        logic [N-1:0] elig;
        logic [N-1:0] np;
        int           win;
        int           idx;
        if (rst) begin
            m_valid = 1'b0;
            m_code  = 0;
            m_ptr   = 0;
            m_pend  = '0;
        end else begin
            elig = m_pend & mask;
            for (int i = 0; i < N; i++) begin
                if (req[i])                             np[i] = 1'b1;
                else if (m_valid && ack && i == m_code) np[i] = 1'b0;
                else                                    np[i] = m_pend[i];
            end
            if (!m_valid) begin
                win = -1;
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (win < 0 && elig[idx]) win = idx;
                end
                if (win >= 0) begin
                    m_valid = 1'b1;
                    m_code  = win;
                end
            end else if (ack) begin
                m_valid = 1'b0;
`ifdef ROUND_ROBIN_EN
                m_ptr = (m_code + 1) % N;
`endif
            end
            m_pend = np;
        end
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mdl_valid",   32'(valid),   32'(m_valid));
            chk("mdl_code",    32'(code),    32'(m_code));
            chk("mdl_onehot",  32'(onehot),  m_valid ? (32'd1 << m_code) : 32'd0);
            chk("mdl_pending", 32'(pending), 32'(m_pend));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; ack = 1'b0; mask = '1;
        tick();
        rst = 1'b0;
    endtask

    int grants[$];

    initial begin
        rst = 1'b1; req = 4'b1111; ack = 1'b1; mask = 4'b1111;
        // 1: reset ignores req/ack
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_valid",   32'(valid),   0);
        chk("rst_code",    32'(code),    0);
        chk("rst_onehot",  32'(onehot),  0);
        chk("rst_pending", 32'(pending), 0);
        rst = 1'b0; req = '0; ack = 1'b0;
        tick(); tick();
        chk("post_rst_valid",   32'(valid),   0);
        chk("post_rst_pending", 32'(pending), 0);

        // 2: single request latency
        req = 4'b0100;
        tick();
        req = '0;
        chk("t2_pend_t1",  32'(pending), 32'h4);
        chk("t2_valid_t1", 32'(valid),   0);
        tick();
        chk("t2_valid", 32'(valid),  1);
        chk("t2_code",  32'(code),   2);
        chk("t2_oh",    32'(onehot), 32'h4);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t2_ack_valid", 32'(valid),   0);
        chk("t2_ack_pend",  32'(pending), 0);

        // 3: two sources, lowest first, one idle bubble
        req = 4'b1010;
        tick();
        req = '0;
        tick();
        chk("t3_code_a", 32'(code), 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t3_bubble", 32'(valid),   0);
        chk("t3_pend",   32'(pending), 32'h8);
        tick();
        chk("t3_valid_b", 32'(valid), 1);
        chk("t3_code_b",  32'(code),  3);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t3_pend_done", 32'(pending), 0);

        // 4: masked source held pending
        mask = 4'b1110; req = 4'b0001;
        tick();
        req = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_masked_valid", 32'(valid),   0);
            chk("t4_masked_pend",  32'(pending), 32'h1);
        end
        mask = 4'b1111;
        tick();
        chk("t4_unmask_valid", 32'(valid), 1);
        chk("t4_unmask_code",  32'(code),  0);
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // 5: grant stability under new req and masking of the granted bit
        req = 4'b1000;
        tick();
        req = '0;
        tick();
        chk("t5_code", 32'(code), 3);
        req = 4'b0001; mask = 4'b0111;
        tick();
        req = '0;
        chk("t5_hold_code", 32'(code),   3);
        chk("t5_hold_oh",   32'(onehot), 32'h8);
        tick();
        chk("t5_hold_code2", 32'(code),  3);
        chk("t5_hold_valid", 32'(valid), 1);
        mask = 4'b1111; ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        chk("t5_next_valid", 32'(valid), 1);
        chk("t5_next_code",  32'(code),  0);
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // 6: continuous requests with eager ack
        do_reset();
        req = 4'b0011; ack = 1'b1;
        for (int c = 0; c < 20 && grants.size() < 4; c++) begin
            tick();
            if (valid) grants.push_back(int'(code));
            if (c > 0) chk("t6_pend_held", 32'(pending), 32'h3);
        end
        chk("t6_count", 32'(grants.size()), 4);
        for (int g = 0; g < 4; g++) begin
`ifdef ROUND_ROBIN_EN
            chk("t6_seq", (g < grants.size()) ? 32'(grants[g]) : 32'hFFFF_FFFF, 32'(g % 2));
`else
            chk("t6_seq", (g < grants.size()) ? 32'(grants[g]) : 32'hFFFF_FFFF, 0);
`endif
        end
        req = '0; ack = 1'b0;

        // Randomized traffic, occasional mid-grant reset
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 149) == 0);
            req  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            mask = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            ack  = ($urandom_range(0, 1) == 1);
            tick();
        end
        rst = 1'b0; req = '0; ack = 1'b0;
        tick();
        @(negedge clk);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
